// File: rtl/rgb_pwm_fader.sv
// RGB LED driver: PWM brightness cap with linear per-channel fades between off and DUTY_MAX.
// Duty changes are applied only at PWM period boundaries so every period is glitch-free.
module rgb_pwm_fader #(
    parameter int unsigned PWM_BITS         = 8,
    parameter int unsigned PWM_DIV          = 16,
    parameter int unsigned DUTY_MAX         = 64,
    parameter int unsigned FADE_STEP_CYCLES = 390625
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic [2:0] rgb_in,
    input  logic       enable,
    output logic       led_r,
    output logic       led_g,
    output logic       led_b,
    output logic       busy
);

    localparam int unsigned DivW  = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam int unsigned FadeW = (FADE_STEP_CYCLES > 1) ? $clog2(FADE_STEP_CYCLES) : 1;

    localparam logic [DivW-1:0]     DivLast  = DivW'(PWM_DIV - 1);
    localparam logic [FadeW-1:0]    FadeLast = FadeW'(FADE_STEP_CYCLES - 1);
    localparam logic [PWM_BITS-1:0] PwmLast  = '1;
    localparam logic [PWM_BITS-1:0] DutyOn   = PWM_BITS'(DUTY_MAX);

    logic [DivW-1:0]          div_cnt_q, div_cnt_d;
    logic [PWM_BITS-1:0]      pwm_cnt_q, pwm_cnt_d;
    logic [FadeW-1:0]         fade_cnt_q, fade_cnt_d;
    logic [2:0][PWM_BITS-1:0] duty_q, duty_d;
    logic [2:0][PWM_BITS-1:0] act_q, act_d;
    logic [2:0][PWM_BITS-1:0] target;
    logic [2:0]               led_q, led_d;
    logic                     busy_q, busy_d;
    logic                     pwm_tick;
    logic                     step;
    logic                     period_end;

    assign pwm_tick   = (div_cnt_q == DivLast);
    assign step       = (fade_cnt_q == FadeLast);
    assign period_end = pwm_tick && (pwm_cnt_q == PwmLast);

    always_comb begin
        div_cnt_d  = pwm_tick ? '0 : div_cnt_q + DivW'(1);
        pwm_cnt_d  = pwm_tick ? pwm_cnt_q + PWM_BITS'(1) : pwm_cnt_q;
        fade_cnt_d = step ? '0 : fade_cnt_q + FadeW'(1);
        busy_d     = 1'b0;
        for (int c = 0; c < 3; c++) begin
            target[c] = rgb_in[c] ? DutyOn : '0;
            duty_d[c] = duty_q[c];
            // A target change mid-ramp simply reverses direction from the current duty.
            if (step) begin
                if (duty_q[c] < target[c]) begin
                    duty_d[c] = duty_q[c] + PWM_BITS'(1);
                end else if (duty_q[c] > target[c]) begin
                    duty_d[c] = duty_q[c] - PWM_BITS'(1);
                end
            end
            act_d[c] = period_end ? duty_q[c] : act_q[c];
            led_d[c] = enable & (pwm_cnt_q < act_q[c]);
            busy_d   = busy_d | (duty_q[c] != target[c]);
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            div_cnt_q  <= '0;
            pwm_cnt_q  <= '0;
            fade_cnt_q <= '0;
            duty_q     <= '0;
            act_q      <= '0;
            led_q      <= '0;
            busy_q     <= 1'b0;
        end else begin
            div_cnt_q  <= div_cnt_d;
            pwm_cnt_q  <= pwm_cnt_d;
            fade_cnt_q <= fade_cnt_d;
            duty_q     <= duty_d;
            act_q      <= act_d;
            led_q      <= led_d;
            busy_q     <= busy_d;
        end
    end

    assign led_r = led_q[2];
    assign led_g = led_q[1];
    assign led_b = led_q[0];
    assign busy  = busy_q;

endmodule
